// File: rtl/apb4_gpio_ext.sv
// rtl/apb4_gpio_ext.sv - APB4 GPIO with input sync, per-pin debounce and edge/level interrupts
module apb4_gpio_ext #(
    parameter int GPIO_NUM    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_WIDTH   = 16
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic [31:0]         paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         pwdata,
    input  logic [3:0]          pstrb,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_dir_o,
    output logic [GPIO_NUM-1:0] gpio_iof_o,
    output logic                irq_o
);

    typedef logic [GPIO_NUM-1:0]  gvec_t;
    typedef logic [DEB_WIDTH-1:0] dcnt_t;

    logic        wr_en;
    logic        rd_en;
    logic [3:0]  reg_addr;
    logic [31:0] byte_mask;
    gvec_t       wmask;
    gvec_t       wdata;
    dcnt_t       dmask;
    gvec_t       w1c_mask;
    logic        unused_paddr;

    gvec_t paddir_q,    paddir_d;
    gvec_t padout_q,    padout_d;
    gvec_t inten_q,     inten_d;
    gvec_t inttype0_q,  inttype0_d;
    gvec_t inttype1_q,  inttype1_d;
    gvec_t intstatus_q, intstatus_d;
    gvec_t iofcfg_q,    iofcfg_d;
    gvec_t deben_q,     deben_d;
    gvec_t intboth_q,   intboth_d;
    dcnt_t debcnt_q,    debcnt_d;

    gvec_t sync_q [SYNC_STAGES];
    gvec_t sync_s;
    gvec_t filt_q, filt_d;
    gvec_t filt_prev_q;
    dcnt_t cnt_q [GPIO_NUM];
    dcnt_t cnt_d [GPIO_NUM];

    gvec_t rise;
    gvec_t fall;
    gvec_t lvl_evt;
    gvec_t edge_evt;
    gvec_t evt;

    assign wr_en        = psel & penable & pwrite;
    assign rd_en        = psel & penable & ~pwrite;
    assign reg_addr     = paddr[5:2];
    assign byte_mask    = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
    assign wmask        = byte_mask[GPIO_NUM-1:0];
    assign wdata        = pwdata[GPIO_NUM-1:0] & wmask;
    assign dmask        = byte_mask[DEB_WIDTH-1:0];
    assign unused_paddr = ^{paddr[31:6], paddr[1:0]};

    assign pready     = 1'b1;
    assign pslverr    = 1'b0;
    assign gpio_out_o = padout_q;
    assign gpio_dir_o = paddir_q;
    assign gpio_iof_o = iofcfg_q;
    assign irq_o      = |intstatus_q;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign rise     = filt_q & ~filt_prev_q;
    assign fall     = ~filt_q & filt_prev_q;
    assign lvl_evt  = ~inttype1_q & ((~inttype0_q & filt_q) | (inttype0_q & ~filt_q));
    assign edge_evt = inttype1_q & ((~inttype0_q & rise) | (inttype0_q & fall));
    assign evt      = (intboth_q & (rise | fall)) | (~intboth_q & (lvl_evt | edge_evt));

    // Register writes with byte strobes; a new interrupt set overrides a same-cycle W1C
    always_comb begin
        paddir_d   = paddir_q;
        padout_d   = padout_q;
        inten_d    = inten_q;
        inttype0_d = inttype0_q;
        inttype1_d = inttype1_q;
        iofcfg_d   = iofcfg_q;
        deben_d    = deben_q;
        debcnt_d   = debcnt_q;
        intboth_d  = intboth_q;
        w1c_mask   = '0;
        if (wr_en) begin
            case (reg_addr)
                4'd0:    paddir_d   = (paddir_q & ~wmask) | wdata;
                4'd2:    padout_d   = (padout_q & ~wmask) | wdata;
                4'd3:    inten_d    = (inten_q & ~wmask) | wdata;
                4'd4:    inttype0_d = (inttype0_q & ~wmask) | wdata;
                4'd5:    inttype1_d = (inttype1_q & ~wmask) | wdata;
                4'd6:    w1c_mask   = wdata;
                4'd7:    iofcfg_d   = (iofcfg_q & ~wmask) | wdata;
                4'd8:    padout_d   = padout_q | wdata;
                4'd9:    padout_d   = padout_q & ~wdata;
                4'd10:   deben_d    = (deben_q & ~wmask) | wdata;
                4'd11:   debcnt_d   = (debcnt_q & ~dmask) | (pwdata[DEB_WIDTH-1:0] & dmask);
                4'd12:   intboth_d  = (intboth_q & ~wmask) | wdata;
                default: ;
            endcase
        end
        intstatus_d = (intstatus_q & ~w1c_mask) | (inten_q & evt);
    end

    // Read mux; the bus reads zero outside a read access and for write-only/unused slots
    always_comb begin
        prdata = '0;
        if (rd_en) begin
            case (reg_addr)
                4'd0:    prdata = 32'(paddir_q);
                4'd1:    prdata = 32'(filt_q);
                4'd2:    prdata = 32'(padout_q);
                4'd3:    prdata = 32'(inten_q);
                4'd4:    prdata = 32'(inttype0_q);
                4'd5:    prdata = 32'(inttype1_q);
                4'd6:    prdata = 32'(intstatus_q);
                4'd7:    prdata = 32'(iofcfg_q);
                4'd10:   prdata = 32'(deben_q);
                4'd11:   prdata = 32'(debcnt_q);
                4'd12:   prdata = 32'(intboth_q);
                default: prdata = '0;
            endcase
        end
    end

    // Per-pin debounce: a differing synchronised value must hold DEBCNT+1 cycles to be accepted
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < GPIO_NUM; i++) begin
            if (!deben_q[i]) begin
                filt_d[i] = sync_s[i];
                cnt_d[i]  = '0;
            end else if (sync_s[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == debcnt_q) begin
                filt_d[i] = sync_s[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEB_WIDTH'(1);
            end
        end
    end

    // Pad input synchroniser chain
    always_ff @(posedge pclk) begin
        if (prst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Register file, filter state and interrupt status
    always_ff @(posedge pclk) begin
        if (prst) begin
            paddir_q    <= '0;
            padout_q    <= '0;
            inten_q     <= '0;
            inttype0_q  <= '0;
            inttype1_q  <= '0;
            intstatus_q <= '0;
            iofcfg_q    <= '0;
            deben_q     <= '0;
            debcnt_q    <= '0;
            intboth_q   <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            for (int i = 0; i < GPIO_NUM; i++) cnt_q[i] <= '0;
        end else begin
            paddir_q    <= paddir_d;
            padout_q    <= padout_d;
            inten_q     <= inten_d;
            inttype0_q  <= inttype0_d;
            inttype1_q  <= inttype1_d;
            intstatus_q <= intstatus_d;
            iofcfg_q    <= iofcfg_d;
            deben_q     <= deben_d;
            debcnt_q    <= debcnt_d;
            intboth_q   <= intboth_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            for (int i = 0; i < GPIO_NUM; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule
